// File: rtl/input_arbiter.sv
// ---------------------------------------------------------------------------
// input_arbiter
//   Lets the SNES, IR and PS2 input decoders share one direction path into the
//   game logic. In auto mode the first controller that produces an active
//   sample becomes the owner. It keeps ownership until it has been idle for
//   TIMEOUT_CYCLES clocks. In forced mode the Choice switch selects the owner.
//   The accepted direction is sanitized and registered.
//
// Ports
//   Clock      in   1  system clock, rising edge
//   Reset_n    in   1  asynchronous active-low reset
//   Choice     in   2  00 auto, 01 force SNES, 10 force IR, 11 force PS2
//   NReadable  in   1  SNES sample strobe
//   NDir       in   4  SNES direction {Up,Down,Left,Right}
//   IReadable  in   1  IR sample strobe
//   IDir       in   4  IR direction {Up,Down,Left,Right}
//   PReadable  in   1  PS2 sample strobe
//   PDir       in   4  PS2 direction {Up,Down,Left,Right}
//   Dir        out  4  accepted, sanitized direction
//   DirValid   out  1  one-cycle pulse when Dir was loaded on this edge
//   Owner      out  2  current owner, Choice encoding (00 = none); this is
//                      the FSM state itself
//   Locked     out  1  an owner is held
//
// Strobe semantics: xReadable is a one-cycle qualifier for xDir. There is no
// back-pressure. An accepted strobe appears on Dir/DirValid one clock later.
// A strobe that is not accepted is dropped.
// ---------------------------------------------------------------------------
module input_arbiter #(
  parameter  int TIMEOUT_CYCLES = 50_000_000,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [1:0] Choice,
  input  logic       NReadable,
  input  logic [3:0] NDir,
  input  logic       IReadable,
  input  logic [3:0] IDir,
  input  logic       PReadable,
  input  logic [3:0] PDir,
  output logic [3:0] Dir,
  output logic       DirValid,
  output logic [1:0] Owner,
  output logic       Locked
);

  // The state encoding matches the Choice/Owner encoding on purpose, so
  // Owner can be taken directly from the state register.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_N = 2'b01,
    ST_OWN_I = 2'b10,
    ST_OWN_P = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_choice;
  logic [3:0]       r_dir;
  logic [3:0]       w_dir_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_choice_chg;
  logic [1:0]       w_src;
  logic             w_src_rd;
  logic [3:0]       w_src_dir;
  logic             w_act_n;
  logic             w_act_i;
  logic             w_act_p;

  // If Up and Down are both pressed, they cancel each other. The same applies
  // to Left and Right.
  function automatic logic [3:0] sanitize(input logic [3:0] d);
    logic [3:0] s;
    s = d;
    if (d[3] && d[2]) s[3:2] = 2'b00;
    if (d[1] && d[0]) s[1:0] = 2'b00;
    return s;
  endfunction

  assign w_choice_chg = (Choice != r_choice);
  assign w_act_n      = NReadable && (NDir != 4'b0000);
  assign w_act_i      = IReadable && (IDir != 4'b0000);
  assign w_act_p      = PReadable && (PDir != 4'b0000);

  // Only one source is listened to while an owner is held. That source is the
  // forced one, or the current owner in auto mode. In IDLE this selects
  // nothing.
  assign w_src = (Choice != 2'b00) ? Choice : r_state;

  always_comb begin
    w_src_rd  = 1'b0;
    w_src_dir = 4'b0000;
    case (w_src)
      2'b01:   begin w_src_rd = NReadable; w_src_dir = NDir; end
      2'b10:   begin w_src_rd = IReadable; w_src_dir = IDir; end
      2'b11:   begin w_src_rd = PReadable; w_src_dir = PDir; end
      default: begin w_src_rd = 1'b0;      w_src_dir = 4'b0000; end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_valid_nxt = 1'b0;
    w_cnt_nxt   = r_cnt;
    if (w_choice_chg) begin
      // Switching modes drops any strobe that arrives in the same cycle.
      w_state_nxt = state_t'(Choice);
      w_dir_nxt   = 4'b0000;
      w_cnt_nxt   = '0;
    end else if (Choice != 2'b00) begin
      w_state_nxt = state_t'(Choice);
      w_cnt_nxt   = '0;
      if (w_src_rd) begin
        w_dir_nxt   = sanitize(w_src_dir);
        w_valid_nxt = 1'b1;
      end
    end else if (r_state == ST_IDLE) begin
      w_cnt_nxt = '0;
      if (w_act_n) begin
        w_state_nxt = ST_OWN_N;
        w_dir_nxt   = sanitize(NDir);
        w_valid_nxt = 1'b1;
      end else if (w_act_i) begin
        w_state_nxt = ST_OWN_I;
        w_dir_nxt   = sanitize(IDir);
        w_valid_nxt = 1'b1;
      end else if (w_act_p) begin
        w_state_nxt = ST_OWN_P;
        w_dir_nxt   = sanitize(PDir);
        w_valid_nxt = 1'b1;
      end
    end else if (w_src_rd) begin
      // Any owner strobe keeps ownership, including a zero direction. It also
      // overrides a timeout that would happen in the same cycle.
      w_dir_nxt   = sanitize(w_src_dir);
      w_valid_nxt = 1'b1;
      w_cnt_nxt   = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_state_nxt = ST_IDLE;
      w_dir_nxt   = 4'b0000;
      w_cnt_nxt   = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_choice <= 2'b00;
      r_dir    <= 4'b0000;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_choice <= Choice;
      r_dir    <= w_dir_nxt;
      r_valid  <= w_valid_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign Dir      = r_dir;
  assign DirValid = r_valid;
  assign Owner    = r_state;
  assign Locked   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_input_arbiter.sv
module tb_input_arbiter;

  localparam int TO = 16;

  logic       Clock;
  logic       Reset_n;
  logic [1:0] Choice;
  logic       NReadable, IReadable, PReadable;
  logic [3:0] NDir, IDir, PDir;
  logic [3:0] Dir;
  logic       DirValid;
  logic [1:0] Owner;
  logic       Locked;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the path, what was last accepted, and how long
  // the owner has been silent.
  int         m_owner;
  logic [3:0] m_dir;
  logic       m_valid;
  int         m_quiet;
  int         m_prev_choice;

  input_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Choice(Choice),
    .NReadable(NReadable), .NDir(NDir),
    .IReadable(IReadable), .IDir(IDir),
    .PReadable(PReadable), .PDir(PDir),
    .Dir(Dir), .DirValid(DirValid), .Owner(Owner), .Locked(Locked)
  );

  // clock / reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [3:0] m_sanitize(input logic [3:0] d);
    int up, dn, lf, rt;
    up = d[3]; dn = d[2]; lf = d[1]; rt = d[0];
    if (up + dn == 2) begin up = 0; dn = 0; end
    if (lf + rt == 2) begin lf = 0; rt = 0; end
    return 4'(up * 8 + dn * 4 + lf * 2 + rt);
  endfunction

  function automatic void model_reset();
    m_owner = 0; m_dir = 4'b0000; m_valid = 1'b0; m_quiet = 0; m_prev_choice = 0;
  endfunction

  function automatic void model_step();
    bit         rd[4];
    logic [3:0] dr[4];
    int         ch;
    ch = int'(Choice);
    rd[0] = 0;         dr[0] = 4'b0000;
    rd[1] = NReadable; dr[1] = NDir;
    rd[2] = IReadable; dr[2] = IDir;
    rd[3] = PReadable; dr[3] = PDir;
    m_valid = 1'b0;
    if (ch != m_prev_choice) begin
      m_owner = ch; m_dir = 4'b0000; m_quiet = 0;
    end else if (ch != 0) begin
      m_owner = ch; m_quiet = 0;
      if (rd[ch]) begin m_dir = m_sanitize(dr[ch]); m_valid = 1'b1; end
    end else if (m_owner == 0) begin
      for (int k = 1; k <= 3; k++) begin
        if (m_owner == 0 && rd[k] && dr[k] != 4'b0000) begin
          m_owner = k; m_dir = m_sanitize(dr[k]); m_valid = 1'b1; m_quiet = 0;
        end
      end
    end else if (rd[m_owner]) begin
      m_dir = m_sanitize(dr[m_owner]); m_valid = 1'b1; m_quiet = 0;
    end else begin
      m_quiet++;
      if (m_quiet == TO) begin m_owner = 0; m_dir = 4'b0000; m_quiet = 0; end
    end
    m_prev_choice = ch;
  endfunction

  function automatic logic [7:0] model_vec();
    return {2'(m_owner), (m_owner != 0), m_dir, m_valid};
  endfunction

  // driver tasks
  task automatic quiet_inputs();
    NReadable = 0; IReadable = 0; PReadable = 0;
    NDir = 4'b0000; IDir = 4'b0000; PDir = 4'b0000;
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    quiet_inputs();
    Choice  = 2'b00;
    Reset_n = 1'b0;
    model_reset();
    #2;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bit seen_bad;
    Reset_n = 1'b0;
    quiet_inputs();
    Choice = 2'b00;
    model_reset();
    #2;
    n_checks++;
    if ({Owner, Locked, Dir, DirValid} !== 8'h00)
      $display("FAIL reset_state: got %b want 00000000", {Owner, Locked, Dir, DirValid});
    else n_pass++;
    Reset_n = 1'b1;
    seen_bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DirValid !== 1'b0 || Owner !== 2'b00 || Locked !== 1'b0 || Dir !== 4'b0000) seen_bad = 1;
    end
    n_checks++;
    if (seen_bad)
      $display("FAIL reset_idle40: got owner=%b locked=%b dir=%b valid=%b want all 0",
               Owner, Locked, Dir, DirValid);
    else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    NReadable = 1; NDir = 4'b1000; IReadable = 1; IDir = 4'b0100;
    tick();
    quiet_inputs();
    n_checks++;
    if ({Owner, Locked, Dir, DirValid} !== 8'b01_1_1000_1)
      $display("FAIL prio_grant: got %b want 01110001", {Owner, Locked, Dir, DirValid});
    else n_pass++;
    tick();
    n_checks++;
    if (DirValid !== 1'b0) $display("FAIL prio_pulse_len: got valid=%b want 0", DirValid);
    else n_pass++;
    IReadable = 1; IDir = 4'b0010;
    tick();
    quiet_inputs();
    n_checks++;
    if ({Owner, Dir, DirValid} !== 7'b01_1000_0)
      $display("FAIL prio_ignore_ir: got %b want 0110000", {Owner, Dir, DirValid});
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    IReadable = 1; IDir = 4'b0001;
    tick();
    quiet_inputs();
    for (int i = 0; i < TO - 1; i++) tick();
    n_checks++;
    if (Owner !== 2'b10 || Locked !== 1'b1)
      $display("FAIL timeout_hold15: got owner=%b locked=%b want 10/1", Owner, Locked);
    else n_pass++;
    tick();
    n_checks++;
    if ({Owner, Locked, Dir, DirValid} !== 8'h00)
      $display("FAIL timeout_release: got %b want 00000000", {Owner, Locked, Dir, DirValid});
    else n_pass++;
    IReadable = 1; IDir = 4'b0010;
    tick();
    quiet_inputs();
    for (int i = 0; i < TO - 1; i++) tick();
    IReadable = 1; IDir = 4'b0000;
    tick();
    quiet_inputs();
    n_checks++;
    if ({Owner, Dir, DirValid} !== 7'b10_0000_1)
      $display("FAIL timeout_strobe_wins: got %b want 1000001", {Owner, Dir, DirValid});
    else n_pass++;
    tick();
    n_checks++;
    if (Owner !== 2'b10) $display("FAIL timeout_after_rescue: got owner=%b want 10", Owner);
    else n_pass++;
  endtask

  task automatic test_forced();
    logic [3:0] pats [3];
    logic [3:0] want [3];
    bit         lost;
    pats[0] = 4'b1100; pats[1] = 4'b0011; pats[2] = 4'b1010;
    want[0] = 4'b0000; want[1] = 4'b0000; want[2] = 4'b1010;
    do_reset();
    Choice = 2'b11;
    tick();
    n_checks++;
    if ({Owner, Locked, DirValid} !== 4'b11_1_0)
      $display("FAIL forced_enter: got %b want 1110", {Owner, Locked, DirValid});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      PReadable = 1; PDir = pats[i];
      tick();
      quiet_inputs();
      n_checks++;
      if ({Dir, DirValid} !== {want[i], 1'b1})
        $display("FAIL forced_sanitize_%0d: got dir=%b valid=%b want %b/1", i, Dir, DirValid, want[i]);
      else n_pass++;
    end
    NReadable = 1; NDir = 4'b0100;
    tick();
    quiet_inputs();
    n_checks++;
    if ({Owner, Dir, DirValid} !== 7'b11_1010_0)
      $display("FAIL forced_ignore_n: got %b want 1110100", {Owner, Dir, DirValid});
    else n_pass++;
    lost = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (Owner !== 2'b11) lost = 1;
    end
    n_checks++;
    if (lost) $display("FAIL forced_no_timeout: got owner=%b want 11", Owner);
    else n_pass++;
  endtask

  task automatic test_choice_change();
    do_reset();
    NReadable = 1; NDir = 4'b0001;
    tick();
    quiet_inputs();
    n_checks++;
    if ({Owner, Dir} !== 6'b01_0001)
      $display("FAIL chg_setup: got %b want 010001", {Owner, Dir});
    else n_pass++;
    Choice = 2'b10; NReadable = 1; NDir = 4'b1000;
    tick();
    quiet_inputs();
    n_checks++;
    if ({Owner, Locked, Dir, DirValid} !== 8'b10_1_0000_0)
      $display("FAIL chg_to_ir: got %b want 10100000", {Owner, Locked, Dir, DirValid});
    else n_pass++;
    Choice = 2'b00;
    tick();
    n_checks++;
    if ({Owner, Locked, DirValid} !== 4'b0000)
      $display("FAIL chg_to_auto: got %b want 0000", {Owner, Locked, DirValid});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    PReadable = 1; PDir = 4'b0100;
    tick();
    quiet_inputs();
    n_checks++;
    if ({Owner, Dir} !== 6'b11_0100)
      $display("FAIL arst_setup: got %b want 110100", {Owner, Dir});
    else n_pass++;
    #3;
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({Owner, Locked, Dir, DirValid} !== 8'h00)
      $display("FAIL arst_immediate: got %b want 00000000", {Owner, Locked, Dir, DirValid});
    else n_pass++;
    Reset_n = 1'b1;
    model_reset();
    #1;
    PReadable = 1; PDir = 4'b0001; IReadable = 1; IDir = 4'b1000;
    tick();
    quiet_inputs();
    n_checks++;
    if ({Owner, Dir, DirValid} !== 7'b10_1000_1)
      $display("FAIL arst_i_beats_p: got %b want 1010001", {Owner, Dir, DirValid});
    else n_pass++;
  endtask

  task automatic test_random();
    int dens;
    do_reset();
    dens = 3;
    for (int i = 0; i < 1200; i++) begin
      if (i % 200 == 0) dens = (i % 400 == 0) ? 3 : 24;
      if ($urandom_range(0, 59) == 0)
        Choice = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      NReadable = ($urandom_range(0, dens) == 0); NDir = 4'($urandom_range(0, 15));
      IReadable = ($urandom_range(0, dens) == 0); IDir = 4'($urandom_range(0, 15));
      PReadable = ($urandom_range(0, dens) == 0); PDir = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if ({Owner, Locked, Dir, DirValid} !== model_vec())
        $display("FAIL random_cycle_%0d: got %b want %b", i, {Owner, Locked, Dir, DirValid}, model_vec());
      else n_pass++;
    end
    quiet_inputs();
  endtask

  initial begin
    Reset_n = 1'b0;
    Choice  = 2'b00;
    quiet_inputs();
    model_reset();
    test_reset();
    test_priority();
    test_timeout();
    test_forced();
    test_choice_change();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
